// File: rtl/data_memory_ctrl.sv
// Byte-addressable big-endian data memory behind valid/ready request/response channels.
// Latency: response WAIT_STATES+1 cycles after the accept cycle; response held until rsp_ready.
module data_memory_ctrl #(
  parameter int DEPTH_BYTES      = 1024,
  parameter int WAIT_STATES      = 1,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_length,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);
  localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        lat_write, lat_unsigned;
  logic [31:0] lat_addr, lat_wdata;
  logic [1:0]  lat_length;
  logic [7:0]  mem [DEPTH_BYTES];

  logic        accept, enter_resp;
  logic        act_write, act_unsigned;
  logic [31:0] act_addr, act_wdata;
  logic [1:0]  act_length;
  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        misaligned, fault;
  logic [AW-1:0] idx [4];
  logic [7:0]  rd_byte [4];
  logic [31:0] load_data;

  assign accept = (state == IDLE) && req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (accept) begin
        cnt_nxt   = 4'(WAIT_STATES);
        state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == RESP) && (state != RESP);

  // With zero wait states the access resolves on the accept edge, so use live request fields.
  assign act_write    = (state == IDLE) ? req_write    : lat_write;
  assign act_unsigned = (state == IDLE) ? req_unsigned : lat_unsigned;
  assign act_addr     = (state == IDLE) ? req_addr     : lat_addr;
  assign act_wdata    = (state == IDLE) ? req_wdata    : lat_wdata;
  assign act_length   = (state == IDLE) ? req_length   : lat_length;

  always_comb begin
    case (act_length)
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      2'd2:    nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
  end

  assign end_addr   = {1'b0, act_addr} + {30'd0, nbytes};
  assign misaligned = !ALLOW_MISALIGNED &&
                      (((act_length == 2'd1) && act_addr[0]) ||
                       ((act_length == 2'd2) && (act_addr[1:0] != 2'b00)));
  assign fault      = (act_length == 2'd3) || (end_addr > 33'(DEPTH_BYTES)) || misaligned;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      idx[i]     = act_addr[AW-1:0] + AW'(i);
      rd_byte[i] = (int'(idx[i]) < DEPTH_BYTES) ? mem[idx[i]] : 8'h00;
    end
  end

  always_comb begin
    case (act_length)
      2'd0:    load_data = {{24{!act_unsigned && rd_byte[0][7]}}, rd_byte[0]};
      2'd1:    load_data = {{16{!act_unsigned && rd_byte[0][7]}}, rd_byte[0], rd_byte[1]};
      default: load_data = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
    endcase
  end

  // RAM array is deliberately not reset; stores are all-or-nothing.
  always_ff @(posedge clk) begin
    if (enter_resp && act_write && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (i < int'(nbytes)) mem[idx[i]] <= act_wdata[31-8*i -: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      req_ready    <= 1'b0;
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
      lat_length   <= 2'd0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_error    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_ready <= (state_nxt == IDLE);
      if (accept) begin
        lat_write    <= req_write;
        lat_unsigned <= req_unsigned;
        lat_addr     <= req_addr;
        lat_wdata    <= req_wdata;
        lat_length   <= req_length;
      end
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_error <= fault;
        rsp_rdata <= (fault || act_write) ? 32'd0 : load_data;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_error <= 1'b0;
        rsp_rdata <= 32'd0;
      end
    end
  end
endmodule
